// File: rtl/apb3_regfile_slave.sv
// APB3 slave exposing NUM_REGS read/write data registers and a sticky, maskable
// interrupt block. PREADY inserts WAIT_STATES wait cycles; PSLVERR flags bad addresses.
module apb3_regfile_slave #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 8,
    parameter int                NUM_IRQ     = 4,
    parameter int                WAIT_STATES = 0,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic [DATA_W-1:0]          pwdata,
    input  logic                       pwrite,
    input  logic                       psel,
    input  logic                       penable,
    output logic [DATA_W-1:0]          prdata,
    output logic                       pready,
    output logic                       pslverr,
    input  logic [NUM_IRQ-1:0]         irq_src,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic                       irq_out
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    state_t              state, state_d;
    logic [3:0]          wcnt, wcnt_d;
    logic                pready_d, pslverr_d;
    logic [DATA_W-1:0]   prdata_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_IRQ-1:0]  irq_stat, irq_en, src_q, irq_set, irq_clr;

    logic                setup, commit, wr_en;
    logic [ADDR_W-1:0]   acc_addr, off;
    logic                acc_write, acc_err;
    logic [DATA_W-1:0]   rd_data;

    // Decode the live bus during setup so a zero-wait response is ready in the access cycle.
    assign setup     = (state == IDLE) && psel && !penable;
    assign acc_addr  = (state == IDLE) ? paddr  : addr_q;
    assign acc_write = (state == IDLE) ? pwrite : write_q;
    assign off       = (acc_addr - BASE_ADDR) >> 2;
    assign acc_err   = (acc_addr < BASE_ADDR) || (acc_addr[1:0] != 2'b00) ||
                       (off > ADDR_W'(NUM_REGS + 1));

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (off == ADDR_W'(k)) rd_data = regs[k];
        end
        if (off == ADDR_W'(NUM_REGS))     rd_data[NUM_IRQ-1:0] = irq_stat;
        if (off == ADDR_W'(NUM_REGS + 1)) rd_data[NUM_IRQ-1:0] = irq_en;
        if (acc_err || acc_write)         rd_data = '0;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state;
        wcnt_d    = wcnt;
        pready_d  = pready;
        prdata_d  = prdata;
        pslverr_d = pslverr;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                pready_d  = 1'b0;
                prdata_d  = '0;
                pslverr_d = 1'b0;
                wcnt_d    = '0;
                if (setup) begin
                    state_d = ACCESS;
                    wcnt_d  = WAIT_CNT;
                    if (WAIT_STATES == 0) begin
                        pready_d  = 1'b1;
                        prdata_d  = rd_data;
                        pslverr_d = acc_err;
                    end
                end
            end
            ACCESS: begin
                if (!psel || (penable && pready)) begin
                    commit    = psel;
                    state_d   = IDLE;
                    wcnt_d    = '0;
                    pready_d  = 1'b0;
                    prdata_d  = '0;
                    pslverr_d = 1'b0;
                end else if (wcnt != 4'd0) begin
                    wcnt_d = wcnt - 4'd1;
                    if (wcnt == 4'd1) begin
                        pready_d  = 1'b1;
                        prdata_d  = rd_data;
                        pslverr_d = acc_err;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            wcnt    <= '0;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state   <= state_d;
            wcnt    <= wcnt_d;
            pready  <= pready_d;
            prdata  <= prdata_d;
            pslverr <= pslverr_d;
            if (setup) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
            end
        end
    end

    assign wr_en   = commit && write_q && !acc_err;
    assign irq_set = irq_src & ~src_q;
    assign irq_clr = (wr_en && off == ADDR_W'(NUM_REGS)) ? wdata_q[NUM_IRQ-1:0] : '0;

    // NOTE: the register array is reset element by element; software relies on a known zero state.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
            irq_stat <= '0;
            irq_en   <= '0;
            src_q    <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_en && off == ADDR_W'(k)) regs[k] <= wdata_q;
            end
            // A new edge outranks a simultaneous write-1-to-clear.
            irq_stat <= (irq_stat & ~irq_clr) | irq_set;
            src_q    <= irq_src;
            if (wr_en && off == ADDR_W'(NUM_REGS + 1)) irq_en <= wdata_q[NUM_IRQ-1:0];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_W +: DATA_W] = regs[g];
    end

    assign irq_out = |(irq_stat & irq_en);

endmodule

// File: tb/tb_apb3_regfile_slave.sv
// Self-checking bench: two slaves (0 and 3 wait states) on one APB bus, directed
// steps plus random traffic, checked against an address-map level reference model.
module tb_apb3_regfile_slave;

    localparam int          NR   = 8;
    localparam int          NI   = 4;
    localparam logic [31:0] BASE = 32'h4000_0100;

    logic              pclk = 1'b0;
    logic              presetn;
    logic [31:0]       paddr, pwdata;
    logic              pwrite, penable;
    logic [1:0]        psel;
    logic [NI-1:0]     irq_src;
    logic [31:0]       prdata  [2];
    logic              pready  [2];
    logic              pslverr [2];
    logic              irq_out [2];
    logic [NR*32-1:0]  reg_out [2];

    logic [31:0]       m_regs [2][NR];
    logic [NI-1:0]     m_stat [2];
    logic [NI-1:0]     m_en   [2];

    int tests = 0;
    int fails = 0;

    always #5 pclk = ~pclk;

    apb3_regfile_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .NUM_IRQ(NI),
                         .WAIT_STATES(0), .BASE_ADDR(BASE)) u_dut0 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel[0]), .penable(penable), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]), .irq_src(irq_src), .reg_out(reg_out[0]), .irq_out(irq_out[0]));

    apb3_regfile_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .NUM_IRQ(NI),
                         .WAIT_STATES(3), .BASE_ADDR(BASE)) u_dut3 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel[1]), .penable(penable), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]), .irq_src(irq_src), .reg_out(reg_out[1]), .irq_out(irq_out[1]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a);
        logic [31:0] o;
        if (a < BASE || a[1:0] != 2'b00) return 1'b1;
        o = (a - BASE) >> 2;
        return o > NR + 1;
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        logic [31:0] o;
        if (addr_err(a)) return 32'h0;
        o = (a - BASE) >> 2;
        if (o < NR)  return m_regs[d][o];
        if (o == NR) return {{(32-NI){1'b0}}, m_stat[d]};
        return {{(32-NI){1'b0}}, m_en[d]};
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] o;
        if (addr_err(a)) return;
        o = (a - BASE) >> 2;
        if (o < NR)       m_regs[d][o] = w;
        else if (o == NR) m_stat[d] = m_stat[d] & ~w[NI-1:0];
        else              m_en[d] = w[NI-1:0];
    endtask

    task automatic model_reset();
        for (int e = 0; e < 2; e++) begin
            for (int k = 0; k < NR; k++) m_regs[e][k] = 32'h0;
            m_stat[e] = '0;
            m_en[e]   = '0;
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] w,
                            input int abort_at, input logic [NI-1:0] pulse,
                            output logic [31:0] rd, output logic err, output int waits);
        waits = 0; rd = 32'h0; err = 1'b0;
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = w;
        @(posedge pclk); #1;
        penable = 1'b1;
        while (pready[d] !== 1'b1) begin
            check("wait_prdata", prdata[d], 32'h0);
            check("wait_pslverr", {31'b0, pslverr[d]}, 32'h0);
            if (waits == abort_at || waits >= 20) begin
                if (waits >= 20) check("pready_timeout", {31'b0, pready[d]}, 32'h1);
                psel[d] = 1'b0; penable = 1'b0;
                @(posedge pclk); #1;
                return;
            end
            @(posedge pclk); #1;
            waits++;
        end
        rd  = prdata[d];
        err = pslverr[d];
        irq_src = irq_src | pulse;
        @(posedge pclk); #1;
        psel[d] = 1'b0; penable = 1'b0;
        irq_src = irq_src & ~pulse;
        if (wr) model_write(d, a, w);
        for (int e = 0; e < 2; e++) m_stat[e] = m_stat[e] | pulse;
    endtask

    task automatic do_xfer(input string tag, input int d, input logic wr, input logic [31:0] a,
                           input logic [31:0] w, input logic [NI-1:0] pulse);
        logic [31:0] exp_rd, rd;
        logic        err;
        int          waits;
        exp_rd = model_read(d, a);
        apb_xfer(d, wr, a, w, -1, pulse, rd, err, waits);
        check({tag, "_waits"}, waits, (d == 0) ? 32'd0 : 32'd3);
        check({tag, "_pslverr"}, {31'b0, err}, {31'b0, addr_err(a)});
        if (!wr) check({tag, "_prdata"}, rd, exp_rd);
    endtask

    task automatic check_state(input int d);
        for (int k = 0; k < NR; k++)
            check($sformatf("reg_out%0d_%0d", d, k), reg_out[d][k*32 +: 32], m_regs[d][k]);
        check($sformatf("irq_out%0d", d), {31'b0, irq_out[d]}, {31'b0, |(m_stat[d] & m_en[d])});
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int e = 0; e < 2; e++) begin
            check({tag, "_pready"},  {31'b0, pready[e]},  32'h0);
            check({tag, "_pslverr"}, {31'b0, pslverr[e]}, 32'h0);
            check({tag, "_prdata"},  prdata[e], 32'h0);
            check_state(e);
        end
    endtask

    task automatic pulse_irq(input logic [NI-1:0] mask);
        irq_src = irq_src | mask;
        @(posedge pclk); #1;
        irq_src = irq_src & ~mask;
        for (int e = 0; e < 2; e++) m_stat[e] = m_stat[e] | mask;
    endtask

    initial begin
        logic [31:0] rd, a;
        logic        err;
        int          waits, d, sel;
        logic        wr;

        presetn = 1'b0; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; irq_src = '0;
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        check_idle_outputs("reset");
        presetn = 1'b1;
        @(posedge pclk); #1;

        // Zero wait states: write then read back offset 0.
        do_xfer("t1_wr", 0, 1'b1, BASE, 32'hA5A5_0001, '0);
        do_xfer("t1_rd", 0, 1'b0, BASE, 32'h0, '0);
        check_state(0);

        // Three wait states: read offset 1, then a write/read pair.
        do_xfer("t2_rd", 1, 1'b0, BASE + 4, 32'h0, '0);
        do_xfer("t2_wr", 1, 1'b1, BASE + 4, 32'h0BAD_F00D, '0);
        do_xfer("t2_rd2", 1, 1'b0, BASE + 4, 32'h0, '0);
        check_state(1);

        // Error responses: out-of-map, misaligned, below base.
        do_xfer("t3_rd_oob", 0, 1'b0, BASE + 4 * (NR + 2), 32'h0, '0);
        do_xfer("t3_wr_mis", 0, 1'b1, BASE + 2, 32'hFFFF_FFFF, '0);
        do_xfer("t3_wr_low", 0, 1'b1, BASE - 4, 32'hFFFF_FFFF, '0);
        do_xfer("t3_rd_oob3", 1, 1'b0, BASE + 4 * (NR + 2), 32'h0, '0);
        check_state(0);
        check_state(1);

        // Random traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            d   = $urandom_range(0, 1);
            wr  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = BASE + 4 * $urandom_range(0, NR + 1);
            else if (sel == 7) a = BASE + 4 * $urandom_range(NR + 2, NR + 20);
            else if (sel == 8) a = BASE + 4 * $urandom_range(0, NR + 1) + $urandom_range(1, 3);
            else               a = BASE - 4 * $urandom_range(1, 8);
            do_xfer("rand", d, wr, a, $urandom, '0);
            check_state(d);
        end

        // Interrupts: enable 0x5, pulse sources 0 and 1, then W1C.
        do_xfer("t4_clr", 0, 1'b1, BASE + 4 * NR, 32'hF, '0);
        do_xfer("t4_en", 0, 1'b1, BASE + 4 * (NR + 1), 32'h5, '0);
        do_xfer("t4_en_rd", 0, 1'b0, BASE + 4 * (NR + 1), 32'h0, '0);
        pulse_irq(4'b0011);
        check_state(0);
        check_state(1);
        do_xfer("t4_stat", 0, 1'b0, BASE + 4 * NR, 32'h0, '0);
        do_xfer("t4_w1c", 0, 1'b1, BASE + 4 * NR, 32'h1, '0);
        do_xfer("t4_stat2", 0, 1'b0, BASE + 4 * NR, 32'h0, '0);
        check_state(0);
        do_xfer("t4_w1c_set", 0, 1'b1, BASE + 4 * NR, 32'h1, 4'b0001);
        check_state(0);
        check_state(1);
        do_xfer("t4_stat3", 0, 1'b0, BASE + 4 * NR, 32'h0, '0);

        // Abort mid-wait on the 3-wait-state slave: nothing commits.
        apb_xfer(1, 1'b1, BASE + 8, 32'h1234_5678, 1, '0, rd, err, waits);
        check_state(1);
        do_xfer("t5_abort_rd", 1, 1'b0, BASE + 8, 32'h0, '0);

        // Reset while the zero-wait slave is presenting read data.
        do_xfer("t5_pre", 0, 1'b1, BASE, 32'hDEAD_BEEF, '0);
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = BASE;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("t5_live_pready", {31'b0, pready[0]}, 32'h1);
        check("t5_live_prdata", prdata[0], 32'hDEAD_BEEF);
        #2 presetn = 1'b0;
        #1;
        model_reset();
        check_idle_outputs("t5_rst");
        psel = 2'b00; penable = 1'b0;
        irq_src = 4'b0100;
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        for (int e = 0; e < 2; e++) m_stat[e] = 4'b0100;
        irq_src = '0;
        do_xfer("t5_stat", 0, 1'b0, BASE + 4 * NR, 32'h0, '0);
        do_xfer("t5_stat3", 1, 1'b0, BASE + 4 * NR, 32'h0, '0);
        do_xfer("t5_wr", 1, 1'b1, BASE + 12, 32'hCAFE_0003, '0);
        do_xfer("t5_rd", 1, 1'b0, BASE + 12, 32'h0, '0);
        check_state(0);
        check_state(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
